// File: rtl/encoder_pkg.sv
// Shared definitions for the draining 8:3 encoder: default sizes and FSM state encoding.
package encoder_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/encoder_8_3_drain_pri_pick.sv
// Combinational picker: selects one set bit of vec and returns its index plus vec with that bit cleared.
// Fixed priority (highest index wins) by default; ROUND_ROBIN_EN selects a wrap-around search from ptr.
module pri_pick
  import encoder_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] code,
  output logic [N-1:0] rest
);

`ifdef ROUND_ROBIN_EN
  logic         found;
  logic [W-1:0] idx;

  // N is a power of two, so the W-bit add wraps N-1 -> 0 for free.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    code  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + W'(k);
      if (!found && vec[idx]) begin
        code  = idx;
        found = 1'b1;
      end
    end
    rest       = vec;
    rest[code] = 1'b0;
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Later iterations overwrite earlier ones, so the highest set index wins.
  always_comb begin
    code = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) code = W'(i);
    end
    rest       = vec;
    rest[code] = 1'b0;
  end
`endif

endmodule

// File: rtl/encoder_8_3_drain.sv
// Sequential 8:3 encoder: accepts a multi-hot vector and drains it one index per output handshake.
// Define ROUND_ROBIN_EN for round-robin picking from a persistent pointer; default is fixed priority.
module encoder_8_3_drain
  import encoder_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         busy,
  output logic         zero_err
);

  state_t       state, state_nx;
  logic [N-1:0] pend;
  logic [N-1:0] rest;
  logic [W-1:0] pick_code;
  logic [W-1:0] ptr;
  logic         accept;
  logic         beat;

  pri_pick #(.N(N)) u_pick (
    .vec  (pend),
    .ptr  (ptr),
    .code (pick_code),
    .rest (rest)
  );

  assign in_ready  = (state == IDLE) && en;
  assign out_valid = (state == SERVE) && en;
  assign out_code  = pick_code;
  assign out_last  = out_valid && (rest == '0);
  assign busy      = (state == SERVE);
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept && (in_vec != '0)) state_nx = SERVE;
      SERVE:   if (beat && out_last)         state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= '0;
      zero_err <= 1'b0;
    end else begin
      state    <= state_nx;
      zero_err <= accept && (in_vec == '0);
      if (accept && (in_vec != '0)) pend <= in_vec;
      else if (beat)                pend <= rest;
    end
  end

`ifdef ROUND_ROBIN_EN
  // Pointer survives across vectors so sources sharing a vector get fair service over time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= '0;
    else if (beat) ptr <= pick_code + W'(1);
  end
`else
  assign ptr = '0;
`endif

endmodule
